// File: rtl/gyro_channel_filter.sv
// gyro_channel_filter
//   Per-channel post-processing of packed gyro sample sets. For every channel
//   it keeps the last raw sample, a block average over 2^AVG_LOG samples and a
//   saturated peak magnitude. The registered `out` word carries one of these,
//   chosen by `sel` (channel) and `mode` (raw / average / peak).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   one-cycle strobe, in_data holds a new sample set
//   in_data    CHANNELS packed signed samples, channel 0 in the low bits
//   sel        channel select; values >= CHANNELS give out = 0
//   mode       00 raw, 01 average, 10 peak, 11 raw
//   clr_peak   clear all peak registers (loads the new magnitude with in_valid)
//   out        selected value, registered
//   out_valid  one-cycle pulse when out carries a fresh result for the mode
//   avg_valid  sticky, set once the first averaging block completes
module gyro_channel_filter #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 16,
    parameter int AVG_LOG  = 2,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                mode,
    input  logic                      clr_peak,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic                      avg_valid
);

    localparam int ACC_W = WIDTH + AVG_LOG;

    typedef enum logic [1:0] {
        MODE_RAW     = 2'b00,
        MODE_AVG     = 2'b01,
        MODE_PEAK    = 2'b10,
        MODE_RAW_ALT = 2'b11
    } mode_e;

    logic signed [WIDTH-1:0] sample [CHANNELS];
    logic        [WIDTH-1:0] mag    [CHANNELS];
    logic signed [WIDTH-1:0] raw_q  [CHANNELS];
    logic signed [WIDTH-1:0] avg_q  [CHANNELS];
    logic        [WIDTH-1:0] peak_q [CHANNELS];
    logic signed [ACC_W-1:0] acc_q  [CHANNELS];

    logic [AVG_LOG-1:0] cnt_q;
    logic               blk_done;
    logic               evt_any_q;
    logic               evt_blk_q;
    logic [WIDTH-1:0]   sel_value;
    logic               fresh;

    // Unpack samples and form |sample|, saturating the most negative value.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sample[i] = in_data[i*WIDTH +: WIDTH];
            if (sample[i] == {1'b1, {(WIDTH-1){1'b0}}})
                mag[i] = {1'b0, {(WIDTH-1){1'b1}}};
            else if (sample[i][WIDTH-1])
                mag[i] = unsigned'(-sample[i]);
            else
                mag[i] = unsigned'(sample[i]);
        end
    end

    assign blk_done = in_valid && (cnt_q == '1);

    // Per-channel raw / average / peak state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                raw_q[i]  <= '0;
                avg_q[i]  <= '0;
                peak_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (in_valid) begin
                    raw_q[i] <= sample[i];
                    if (blk_done) begin
                        // Full-width signed sum, then arithmetic shift: floor division.
                        avg_q[i] <= WIDTH'((acc_q[i] + ACC_W'(sample[i])) >>> AVG_LOG);
                        acc_q[i] <= '0;
                    end else begin
                        acc_q[i] <= acc_q[i] + ACC_W'(sample[i]);
                    end
                end
                if (clr_peak)
                    peak_q[i] <= in_valid ? mag[i] : '0;
                else if (in_valid && (mag[i] > peak_q[i]))
                    peak_q[i] <= mag[i];
            end
        end
    end

    // Shared sample counter (wraps from max to 0 with no gap) and event flags
    // that mark which kind of result becomes visible on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            avg_valid <= 1'b0;
            evt_any_q <= 1'b0;
            evt_blk_q <= 1'b0;
        end else begin
            if (in_valid)
                cnt_q <= cnt_q + 1'b1;
            if (blk_done)
                avg_valid <= 1'b1;
            evt_any_q <= in_valid;
            evt_blk_q <= blk_done;
        end
    end

    // Output selection from the already-updated registers.
    always_comb begin
        sel_value = '0;
        fresh     = evt_any_q;
        case (mode_e'(mode))
            MODE_AVG: begin
                fresh = evt_blk_q;
                if (int'(sel) < CHANNELS)
                    sel_value = avg_q[sel];
            end
            MODE_PEAK: begin
                if (int'(sel) < CHANNELS)
                    sel_value = peak_q[sel];
            end
            default: begin
                if (int'(sel) < CHANNELS)
                    sel_value = raw_q[sel];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= sel_value;
            out_valid <= fresh;
        end
    end

endmodule

// File: tb/tb_gyro_channel_filter.sv
module tb_gyro_channel_filter;

    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int AL  = 2;
    localparam int SW  = 2;
    localparam int BLK = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [CH*W-1:0]   in_data;
    logic [SW-1:0]     sel;
    logic [1:0]        mode;
    logic              clr_peak;
    logic [W-1:0]      out;
    logic              out_valid;
    logic              avg_valid;

    always #5 clk = ~clk;

    gyro_channel_filter #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .AVG_LOG (AL),
        .SEL_W   (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .sel      (sel),
        .mode     (mode),
        .clr_peak (clr_peak),
        .out      (out),
        .out_valid(out_valid),
        .avg_valid(avg_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_raw [CH];
    int              m_avg [CH];
    int              m_peak[CH];
    logic [CH*W-1:0] m_blk[$];
    bit              m_avgv, m_last_any, m_last_blk;

    function automatic int s16(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int mag_of(input int s);
        int m;
        m = (s < 0) ? -s : s;
        return (m > 32767) ? 32767 : m;
    endfunction

    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_raw[c] = 0; m_avg[c] = 0; m_peak[c] = 0;
        end
        m_blk.delete();
        m_avgv = 0; m_last_any = 0; m_last_blk = 0;
    endfunction

    function automatic logic [W-1:0] model_out(input logic [SW-1:0] s, input logic [1:0] md);
        int v;
        if (int'(s) >= CH) return '0;
        case (md)
            2'b01:   v = m_avg[s];
            2'b10:   v = m_peak[s];
            default: v = m_raw[s];
        endcase
        return W'(v);
    endfunction

    function automatic void model_edge(input bit iv, input logic [CH*W-1:0] d, input bit clr);
        bit              blk;
        logic [W-1:0]    smp;
        logic [CH*W-1:0] set;
        int              sum;
        blk = 0;
        for (int c = 0; c < CH; c++) begin
            smp = d[c*W +: W];
            if (iv) m_raw[c] = s16(smp);
            if (clr)
                m_peak[c] = iv ? mag_of(s16(smp)) : 0;
            else if (iv && mag_of(s16(smp)) > m_peak[c])
                m_peak[c] = mag_of(s16(smp));
        end
        if (iv) begin
            m_blk.push_back(d);
            if (m_blk.size() == BLK) begin
                for (int c = 0; c < CH; c++) begin
                    sum = 0;
                    for (int k = 0; k < BLK; k++) begin
                        set = m_blk[k];
                        sum += s16(set[c*W +: W]);
                    end
                    m_avg[c] = floor_div(sum, BLK);
                end
                m_blk.delete();
                m_avgv = 1;
                blk = 1;
            end
        end
        m_last_any = iv;
        m_last_blk = blk;
    endfunction

    // One clock cycle, checked against the model. Called at posedge+1.
    task automatic cycle(input bit iv, input logic [CH*W-1:0] d, input logic [SW-1:0] s,
                         input logic [1:0] md, input bit clr, input string tag);
        logic [W-1:0] e_out;
        bit           e_ov;
        in_valid = iv; in_data = d; sel = s; mode = md; clr_peak = clr;
        e_out = model_out(s, md);
        e_ov  = (md == 2'b01) ? m_last_blk : m_last_any;
        model_edge(iv, d, clr);
        @(posedge clk); #1;
        check({tag, " model out"},       32'(out),       32'(e_out));
        check({tag, " model out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, " model avg_valid"}, 32'(avg_valid), 32'(m_avgv));
        in_valid = 1'b0; clr_peak = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        in_valid = 1'b0; clr_peak = 1'b0;
        rst = 1'b1;
        #2;
        check({tag, " async rst out"},       32'(out),       32'h0);
        check({tag, " async rst out_valid"}, 32'(out_valid), 32'h0);
        check({tag, " async rst avg_valid"}, 32'(avg_valid), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r;
        bit          iv;
        logic [15:0] d0, d1, d2;
        logic [1:0]  s, md;
        bit          clr;
        logic [15:0] e_out;
        bit          e_ov, e_av;
    } vec_t;

    vec_t vt[$];

    function automatic void v(input bit r, input bit iv, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [1:0] s, input logic [1:0] md,
                              input bit clr, input logic [15:0] eo, input bit eov, input bit eav);
        vec_t x;
        x.r = r; x.iv = iv; x.d0 = d0; x.d1 = d1; x.d2 = d2; x.s = s; x.md = md; x.clr = clr;
        x.e_out = eo; x.e_ov = eov; x.e_av = eav;
        vt.push_back(x);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string tag;
        logic [CH*W-1:0] d;
        logic [W-1:0]    smp;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; mode = '0; clr_peak = 1'b0;

        // raw
        v(1,0,16'h0,16'h0,16'h0, 2'd1,2'd0,0, 16'h0000,0,0);
        v(0,1,16'h1234,16'hFFFE,16'h8000, 2'd1,2'd0,0, 16'h0000,0,0);
        v(0,0,16'h0,16'h0,16'h0, 2'd1,2'd0,0, 16'hFFFE,1,0);
        v(0,0,16'h0,16'h0,16'h0, 2'd1,2'd0,0, 16'hFFFE,0,0);
        v(0,0,16'h0,16'h0,16'h0, 2'd3,2'd0,0, 16'h0000,0,0);
        // average, ch0
        v(1,0,16'h0,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd10,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd20,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd30,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'hFFFC,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,1);
        v(0,0,16'h0,16'h0,16'h0, 2'd0,2'd1,0, 16'h000E,1,1);
        v(0,1,16'hFFFF,16'h0,16'h0, 2'd0,2'd1,0, 16'h000E,0,1);
        v(0,1,16'hFFFF,16'h0,16'h0, 2'd0,2'd1,0, 16'h000E,0,1);
        v(0,1,16'hFFFF,16'h0,16'h0, 2'd0,2'd1,0, 16'h000E,0,1);
        v(0,1,16'hFFFE,16'h0,16'h0, 2'd0,2'd1,0, 16'h000E,0,1);
        v(0,0,16'h0,16'h0,16'h0, 2'd0,2'd1,0, 16'hFFFE,1,1);
        // peak, ch2
        v(1,0,16'h0,16'h0,16'h0, 2'd2,2'd2,0, 16'h0000,0,0);
        v(0,1,16'h0,16'h0,16'h0064, 2'd2,2'd2,0, 16'h0000,0,0);
        v(0,1,16'h0,16'h0,16'hFED4, 2'd2,2'd2,0, 16'h0064,1,0);
        v(0,1,16'h0,16'h0,16'h00C8, 2'd2,2'd2,0, 16'h012C,1,0);
        v(0,1,16'h0,16'h0,16'h8000, 2'd2,2'd2,0, 16'h012C,1,1);
        v(0,1,16'h0,16'h0,16'h0032, 2'd2,2'd2,1, 16'h7FFF,1,1);
        v(0,0,16'h0,16'h0,16'h0, 2'd2,2'd2,1, 16'h0032,1,1);
        v(0,0,16'h0,16'h0,16'h0, 2'd2,2'd2,0, 16'h0000,0,1);
        // reset mid-block
        v(1,0,16'h0,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd1000,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd1000,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(1,0,16'h0,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd8,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd8,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd8,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,0);
        v(0,1,16'd8,16'h0,16'h0, 2'd0,2'd1,0, 16'h0000,0,1);
        v(0,0,16'h0,16'h0,16'h0, 2'd0,2'd1,0, 16'h0008,1,1);
        // mode switch raw -> peak without a sample
        v(1,0,16'h0,16'h0,16'h0, 2'd2,2'd0,0, 16'h0000,0,0);
        v(0,1,16'h0,16'h0,16'hFFF9, 2'd2,2'd0,0, 16'h0000,0,0);
        v(0,0,16'h0,16'h0,16'h0, 2'd2,2'd0,0, 16'hFFF9,1,0);
        v(0,0,16'h0,16'h0,16'h0, 2'd2,2'd2,0, 16'h0007,0,0);
        v(0,0,16'h0,16'h0,16'h0, 2'd2,2'd2,0, 16'h0007,0,0);

        for (int i = 0; i < vt.size(); i++) begin
            tag = $sformatf("vec%0d", i);
            if (vt[i].r)
                do_reset(tag);
            else
                cycle(vt[i].iv, {vt[i].d2, vt[i].d1, vt[i].d0}, vt[i].s, vt[i].md, vt[i].clr, tag);
            check({tag, " out"},       32'(out),       32'(vt[i].e_out));
            check({tag, " out_valid"}, 32'(out_valid), 32'(vt[i].e_ov));
            check({tag, " avg_valid"}, 32'(avg_valid), 32'(vt[i].e_av));
        end

        // Hand-written: reset while outputs are busy (out, out_valid, avg_valid all set).
        do_reset("busy pre");
        for (int k = 0; k < BLK; k++)
            cycle(1'b1, {16'h0, 16'h0, 16'h1234}, 2'd0, 2'd0, 1'b0, "busy fill");
        check("busy out",       32'(out),       32'h1234);
        check("busy out_valid", 32'(out_valid), 32'h1);
        check("busy avg_valid", 32'(avg_valid), 32'h1);
        #2;
        do_reset("busy");

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand");
            end else begin
                for (int c = 0; c < CH; c++) begin
                    case ($urandom_range(0, 9))
                        0:       smp = 16'h8000;
                        1:       smp = 16'h7FFF;
                        2:       smp = 16'hFFFF;
                        3:       smp = 16'h0001;
                        default: smp = W'($urandom());
                    endcase
                    d[c*W +: W] = smp;
                end
                cycle($urandom_range(0, 99) < 60, d, SW'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                      $sformatf("rand%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
